// File: rtl/tri_scan_writer.sv
// Triangle bounding-box scan writer: walks a clamped box row-major through an external
// fixed-latency inside-test and writes covered pixels to a BRAM port, or clears the frame.
module tri_scan_writer #(
    parameter int unsigned FRAME_WIDTH  = 512,
    parameter int unsigned FRAME_HEIGHT = 384,
    parameter int unsigned COORD_BITS   = 16,
    parameter int unsigned ADDR_BITS    = 18,
    parameter int unsigned COLOR_WIDTH  = 16,
    parameter int unsigned TEST_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tri_valid,
    output logic                   tri_ready,
    input  logic [COORD_BITS-1:0]  tri_xmin,
    input  logic [COORD_BITS-1:0]  tri_xmax,
    input  logic [COORD_BITS-1:0]  tri_ymin,
    input  logic [COORD_BITS-1:0]  tri_ymax,
    input  logic [COLOR_WIDTH-1:0] tri_color,
    input  logic                   clear_req,
    input  logic [COLOR_WIDTH-1:0] clear_color,
    output logic [COORD_BITS-1:0]  test_x,
    output logic [COORD_BITS-1:0]  test_y,
    output logic                   test_valid,
    input  logic                   test_inside,
    output logic                   pix_we,
    output logic [ADDR_BITS-1:0]   pix_addr,
    output logic [COLOR_WIDTH-1:0] pix_data,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned NPIX = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned DW   = $clog2(TEST_LATENCY + 1);
    localparam int unsigned PW   = ADDR_BITS + COORD_BITS;

    localparam logic [CW-1:0] CLR_LAST   = CW'(NPIX - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(TEST_LATENCY - 1);

    localparam logic signed [COORD_BITS-1:0] X_END  = COORD_BITS'(FRAME_WIDTH);
    localparam logic signed [COORD_BITS-1:0] Y_END  = COORD_BITS'(FRAME_HEIGHT);
    localparam logic signed [COORD_BITS-1:0] X_LAST = COORD_BITS'(FRAME_WIDTH - 1);
    localparam logic signed [COORD_BITS-1:0] Y_LAST = COORD_BITS'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t state, state_d;

    logic                   rdy_q;
    logic                   accept;
    logic                   enter_clear;
    logic                   box_empty;
    logic                   scan_last;
    logic                   done_d;

    logic signed [COORD_BITS-1:0] xmin_s, xmax_s, ymin_s, ymax_s;
    logic [COORD_BITS-1:0]  x_lo, x_hi, y_lo, y_hi;

    logic [COORD_BITS-1:0]  bx_lo, bx_hi, by_hi;
    logic [COORD_BITS-1:0]  cur_x, cur_y;
    logic [COLOR_WIDTH-1:0] job_color;
    logic [CW-1:0]          clr_cnt;
    logic [DW-1:0]          drn_cnt;
    logic [ADDR_BITS-1:0]   scan_addr;

    logic [TEST_LATENCY-1:0] pipe_valid;
    logic [ADDR_BITS-1:0]    pipe_addr  [TEST_LATENCY];
    logic [COLOR_WIDTH-1:0]  pipe_color [TEST_LATENCY];

    // Handshake and status; ready is held low until the first edge after reset release.
    assign tri_ready   = rdy_q && (state == IDLE) && !clear_req;
    assign accept      = tri_valid && tri_ready;
    assign enter_clear = rdy_q && (state == IDLE) && clear_req;
    assign busy        = (state != IDLE);
    assign test_valid  = (state == SCAN);
    assign test_x      = cur_x;
    assign test_y      = cur_y;

    // Emptiness is judged on the raw signed box, before clamping.
    assign xmin_s    = $signed(tri_xmin);
    assign xmax_s    = $signed(tri_xmax);
    assign ymin_s    = $signed(tri_ymin);
    assign ymax_s    = $signed(tri_ymax);
    assign box_empty = (xmin_s > xmax_s) || (ymin_s > ymax_s) ||
                       xmax_s[COORD_BITS-1] || ymax_s[COORD_BITS-1] ||
                       (xmin_s >= X_END) || (ymin_s >= Y_END);

    assign x_lo = xmin_s[COORD_BITS-1] ? '0 : tri_xmin;
    assign y_lo = ymin_s[COORD_BITS-1] ? '0 : tri_ymin;
    assign x_hi = (xmax_s > X_LAST) ? X_LAST : tri_xmax;
    assign y_hi = (ymax_s > Y_LAST) ? Y_LAST : tri_ymax;

    assign scan_last = (cur_x == bx_hi) && (cur_y == by_hi);
    assign scan_addr = ADDR_BITS'(PW'(cur_y) * PW'(FRAME_WIDTH) + PW'(cur_x));

    // Write port: clear writes come straight from the counter, scan writes from the pipe tail.
    assign pix_we   = (state == CLEAR) || (pipe_valid[TEST_LATENCY-1] && test_inside);
    assign pix_addr = (state == CLEAR) ? ADDR_BITS'(clr_cnt) : pipe_addr[TEST_LATENCY-1];
    assign pix_data = (state == CLEAR) ? job_color : pipe_color[TEST_LATENCY-1];

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (enter_clear) begin
                    state_d = CLEAR;
                end else if (accept) begin
                    if (box_empty) done_d = 1'b1;
                    else           state_d = SCAN;
                end
            end
            SCAN: begin
                if (scan_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (drn_cnt == DRAIN_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            rdy_q      <= 1'b0;
            bx_lo      <= '0;
            bx_hi      <= '0;
            by_hi      <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            job_color  <= '0;
            clr_cnt    <= '0;
            drn_cnt    <= '0;
            pipe_valid <= '0;
            for (int i = 0; i < int'(TEST_LATENCY); i++) begin
                pipe_addr[i]  <= '0;
                pipe_color[i] <= '0;
            end
        end else begin
            state <= state_d;
            done  <= done_d;
            rdy_q <= 1'b1;

            // Job capture and row-major walk; x wraps back to the clamped left edge.
            if (accept) begin
                bx_lo     <= x_lo;
                bx_hi     <= x_hi;
                by_hi     <= y_hi;
                cur_x     <= x_lo;
                cur_y     <= y_lo;
                job_color <= tri_color;
            end else if (state == SCAN && !scan_last) begin
                if (cur_x == bx_hi) begin
                    cur_x <= bx_lo;
                    cur_y <= cur_y + COORD_BITS'(1);
                end else begin
                    cur_x <= cur_x + COORD_BITS'(1);
                end
            end

            if (enter_clear) begin
                job_color <= clear_color;
                clr_cnt   <= '0;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + CW'(1);
            end

            if (state == DRAIN) drn_cnt <= drn_cnt + DW'(1);
            else                drn_cnt <= '0;

            // Address/color ride alongside the issued pixel until its inside result returns.
            pipe_valid[0] <= test_valid;
            pipe_addr[0]  <= scan_addr;
            pipe_color[0] <= job_color;
            for (int i = 1; i < int'(TEST_LATENCY); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_color[i] <= pipe_color[i-1];
            end
        end
    end

endmodule

// File: doc/tri_scan_writer.md
TRI_SCAN_WRITER -- requirements
Module: tri_scan_writer

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 512, frame width in pixels.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 384, frame height in pixels.
REQ-003 SHALL have parameter COORD_BITS, default 16, signed two's-complement coordinate width.
REQ-004 SHALL have parameter ADDR_BITS, default 18, pixel BRAM address width.
REQ-005 SHALL have parameter COLOR_WIDTH, default 16, padded pixel color width.
REQ-006 SHALL have parameter TEST_LATENCY, default 4 (≥1), fixed cycles from test_x/test_y issue to test_inside.
REQ-007 SHALL have port clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-009 SHALL have ports tri_valid input 1 and tri_ready output 1, forming the triangle-job handshake.
REQ-010 SHALL have ports tri_xmin, tri_xmax, tri_ymin, tri_ymax  input  COORD_BITS  signed bounding box, inclusive.
REQ-011 SHALL have port tri_color  input  COLOR_WIDTH  fill color.
REQ-012 SHALL have ports clear_req input 1 and clear_color input COLOR_WIDTH, giving the full-frame clear request and its color.
REQ-013 SHALL have ports test_x, test_y  output  COORD_BITS  pixel issued to external inside-test; test_valid output 1.
REQ-014 SHALL have port test_inside  input  1  inside result for the pixel issued TEST_LATENCY cycles earlier.
REQ-015 SHALL have ports pix_we output 1, pix_addr output ADDR_BITS and pix_data output COLOR_WIDTH, forming the BRAM write port.
REQ-016 SHALL have ports busy output 1 (state≠IDLE) and done output 1 (one-cycle pulse at job end).

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, CLEAR.
REQ-018 tri_ready SHALL be 1 only in IDLE; accept = tri_valid&&tri_ready; box and color registered on accept.
REQ-019 In IDLE, clear_req SHALL take priority over tri_valid; tri_ready SHALL be 0 in any cycle where clear_req=1.
REQ-020 On accept, box SHALL be clamped: x to [0,FRAME_WIDTH-1], y to [0,FRAME_HEIGHT-1].
REQ-021 Empty box (xmin>xmax, ymin>ymax, xmax<0, ymax<0, xmin≥FRAME_WIDTH or ymin≥FRAME_HEIGHT, checked before clamping) SHALL skip SCAN: done pulses the cycle after accept, state stays IDLE, no writes.
REQ-022 Non-empty accept SHALL enter SCAN; one pixel per cycle, row-major: x from xmin to xmax, then y+1, x wraps to xmin.
REQ-023 In SCAN, test_valid=1 with test_x/test_y = current pixel; after (xmax,ymax) is issued, state SHALL go to DRAIN.
REQ-024 Address and color SHALL travel through an internal TEST_LATENCY-deep pipe alongside test_valid.
REQ-025 pix_we SHALL equal (delayed test_valid)&&test_inside; pix_addr = y*FRAME_WIDTH+x, truncated to ADDR_BITS; pix_data = job color.
REQ-026 DRAIN SHALL last TEST_LATENCY cycles; done SHALL pulse in the cycle after the final pipe output; state then returns to IDLE.
REQ-027 CLEAR SHALL write addresses 0..FRAME_WIDTH*FRAME_HEIGHT-1 in order, one per cycle, pix_we=1, pix_data=clear_color latched at entry, test_valid=0.
REQ-028 After the last CLEAR write, done SHALL pulse the next cycle, with return to IDLE.
REQ-029 tri_valid and clear_req outside IDLE SHALL be ignored (not queued).
REQ-030 Input changes after accept SHALL not affect the running job.

Reset
REQ-031 Reset assertion SHALL act immediately regardless of state, including mid-SCAN/CLEAR, and abort the job.
REQ-032 During reset: state IDLE; tri_ready=0, test_valid=0, pix_we=0, done=0, busy=0.
REQ-033 During reset: pix_addr=0, pix_data=0, test_x=0, test_y=0, all pipe valid bits 0.
REQ-034 tri_ready SHALL rise the first cycle after reset deassertion; no done pulse SHALL result from an aborted job.

Verification
REQ-035 Box (2,3)-(4,4), test_inside=1 constantly, TEST_LATENCY=4 -> 6 writes, addrs 1538,1539,1540,2050,2051,2052; done 6+4+1 cycles after accept.
REQ-036 Box (-5,-5)-(1,0) -> clamped (0,0)-(1,0); exactly 2 writes, addrs 0,1.
REQ-037 Box (600,10)-(700,20) -> no writes, no test_valid; done the cycle after accept.
REQ-038 clear_req=1 and tri_valid=1 same IDLE cycle, clear_color=0x0F00 -> tri not accepted; 196608 writes of 0x0F00; addr 196607 last; then done.
REQ-039 test_inside alternating 1,0 on a 1x4 row at y=0, x=0..3 -> writes at addrs 0 and 2 only.
REQ-040 Reset asserted mid-SCAN of a 10x10 box -> pix_we drops immediately; no done pulse; tri_ready=1 one cycle after release.
